// File: rtl/sprite_pkg.sv
// Shared types and helpers for the player sprite: hit FSM states and red tint.
package sprite_pkg;
   typedef enum logic [1:0] {
      IDLE     = 2'd0,
      FLASH    = 2'd1,
      COOLDOWN = 2'd2
   } hit_state_e;

   localparam logic [3:0] TINT_ADD = 4'hA;

   // Red channel is saturated on its own so nothing spills into green.
   function automatic logic [11:0] tint_pixel(input logic [11:0] px);
      logic [4:0] sum;
      sum = {1'b0, px[11:8]} + {1'b0, TINT_ADD};
      return {(sum[4] ? 4'hF : sum[3:0]), px[7:0]};
   endfunction
endpackage

// File: rtl/vga_pkg.sv
// VGA timing constants and field widths shared by the video pipeline.
// Geometry is 1024x768 active within a 1344x806 frame.
package vga_pkg;
   localparam int HCOUNT_W = 11;
   localparam int VCOUNT_W = 11;
   localparam int RGB_W    = 12;
   localparam int H_ACTIVE = 1024;
   localparam int H_TOTAL  = 1344;
   localparam int V_ACTIVE = 768;
   localparam int V_TOTAL  = 806;
endpackage

// File: rtl/vga_if.sv
// VGA timing plus colour bundle; vga_in is the consumer view, vga_out the producer view.
interface vga_if;
   logic [vga_pkg::HCOUNT_W-1:0] hcount;
   logic [vga_pkg::VCOUNT_W-1:0] vcount;
   logic                         hsync;
   logic                         vsync;
   logic                         hblnk;
   logic                         vblnk;
   logic [vga_pkg::RGB_W-1:0]    rgb;

   modport vga_in  (input  hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
   modport vga_out (output hcount, vcount, hsync, vsync, hblnk, vblnk, rgb);
endinterface

// File: rtl/hit_flash_ctrl.sv
// Hit response controller: edge-detects hit, flashes a blinking tint, then
// ignores hits for a cooldown window. Counts accepted hits, saturating at 255.
module hit_flash_ctrl
   import sprite_pkg::*;
#(
   parameter int unsigned FLASH_TICKS    = 32_500_000,
   parameter int unsigned BLINK_TICKS    = 4_062_500,
   parameter int unsigned COOLDOWN_TICKS = 6_500_000
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       hit,
   output logic       flash_active,
   output logic       tint_on,
   output logic [7:0] hit_cnt
);
   hit_state_e  r_state, w_state_nxt;
   logic [31:0] r_cnt, w_cnt_nxt;
   logic [31:0] r_blink, w_blink_nxt;
   logic        r_tint, w_tint_nxt;
   logic [7:0]  r_hit_cnt, w_hit_cnt_nxt;
   logic        r_hit_d;
   logic        w_hit_edge;

   assign w_hit_edge = hit && !r_hit_d;

   // State and counter registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state   <= IDLE;
         r_cnt     <= 32'd0;
         r_blink   <= 32'd0;
         r_tint    <= 1'b0;
         r_hit_cnt <= 8'd0;
         r_hit_d   <= 1'b0;
      end else begin
         r_state   <= w_state_nxt;
         r_cnt     <= w_cnt_nxt;
         r_blink   <= w_blink_nxt;
         r_tint    <= w_tint_nxt;
         r_hit_cnt <= w_hit_cnt_nxt;
         r_hit_d   <= hit;
      end
   end

   // Next-state logic
   always_comb begin
      w_state_nxt   = r_state;
      w_cnt_nxt     = r_cnt;
      w_blink_nxt   = r_blink;
      w_tint_nxt    = r_tint;
      w_hit_cnt_nxt = r_hit_cnt;
      case (r_state)
         IDLE: begin
            if (w_hit_edge) begin
               w_state_nxt = FLASH;
               w_cnt_nxt   = 32'd0;
               w_blink_nxt = 32'd0;
               w_tint_nxt  = 1'b1;
               if (r_hit_cnt != 8'hFF) begin
                  w_hit_cnt_nxt = r_hit_cnt + 8'd1;
               end else begin
                  w_hit_cnt_nxt = r_hit_cnt;
               end
            end else begin
               w_state_nxt = IDLE;
            end
         end
         FLASH: begin
            if (r_cnt == FLASH_TICKS - 32'd1) begin
               w_state_nxt = (COOLDOWN_TICKS == 32'd0) ? IDLE : COOLDOWN;
               w_cnt_nxt   = 32'd0;
               w_blink_nxt = 32'd0;
               w_tint_nxt  = 1'b0;
            end else begin
               w_cnt_nxt = r_cnt + 32'd1;
               if (r_blink == BLINK_TICKS - 32'd1) begin
                  w_blink_nxt = 32'd0;
                  w_tint_nxt  = !r_tint;
               end else begin
                  w_blink_nxt = r_blink + 32'd1;
               end
            end
         end
         COOLDOWN: begin
            if (r_cnt == COOLDOWN_TICKS - 32'd1) begin
               w_state_nxt = IDLE;
               w_cnt_nxt   = 32'd0;
            end else begin
               w_cnt_nxt = r_cnt + 32'd1;
            end
         end
         default: begin
            w_state_nxt = IDLE;
            w_cnt_nxt   = 32'd0;
            w_blink_nxt = 32'd0;
            w_tint_nxt  = 1'b0;
         end
      endcase
   end

   assign flash_active = (r_state == FLASH);
   assign tint_on      = r_tint;
   assign hit_cnt      = r_hit_cnt;
endmodule

// File: rtl/draw_player_sprite.sv
// Overlays an animated, mirrorable player sprite on the VGA stream with a
// two-stage pipeline; a hit makes the sprite flash red for a while.
module draw_player_sprite
   import sprite_pkg::*;
#(
   parameter int unsigned POS_X          = 880,
   parameter int unsigned POS_Y          = 430,
   parameter int unsigned SPR_W          = 140,
   parameter int unsigned SPR_H          = 151,
   parameter int unsigned FRAMES         = 2,
   parameter int unsigned ADDR_W         = 16,
   parameter logic [11:0] TRANSP_KEY     = 12'h0F0,
   parameter int unsigned FLASH_TICKS    = 32_500_000,
   parameter int unsigned BLINK_TICKS    = 4_062_500,
   parameter int unsigned COOLDOWN_TICKS = 6_500_000,
   localparam int unsigned FS_W          = (FRAMES > 1) ? $clog2(FRAMES) : 1
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              hit,
   input  logic [FS_W-1:0]   frame_sel,
   input  logic              mirror,
   input  logic [11:0]       rgb_pixel,
   output logic [ADDR_W-1:0] rom_addr,
   output logic              flash_active,
   output logic [7:0]        hit_cnt,
   vga_if.vga_in             vga_in,
   vga_if.vga_out            vga_out
);
   logic [10:0]     r_s1_hcount, r_s1_vcount, r_s2_hcount, r_s2_vcount;
   logic            r_s1_hsync, r_s1_vsync, r_s1_hblnk, r_s1_vblnk;
   logic            r_s2_hsync, r_s2_vsync, r_s2_hblnk, r_s2_vblnk;
   logic [11:0]     r_s1_rgb, r_s2_rgb;
   logic            r_s2_inside;
   logic [FS_W-1:0] r_frame;
   logic            r_mirror;
   logic [31:0]     w_rel_x, w_rel_y, w_col, w_addr_full;
   logic            w_inside, w_tint_on;
   logic [11:0]     w_rgb_out;

   // Stage 1, plus frame/mirror latched at vblank rise so a frame never tears
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s1_hcount <= 11'd0;
         r_s1_vcount <= 11'd0;
         r_s1_hsync  <= 1'b0;
         r_s1_vsync  <= 1'b0;
         r_s1_hblnk  <= 1'b0;
         r_s1_vblnk  <= 1'b0;
         r_s1_rgb    <= 12'h000;
         r_frame     <= '0;
         r_mirror    <= 1'b0;
      end else begin
         r_s1_hcount <= vga_in.hcount;
         r_s1_vcount <= vga_in.vcount;
         r_s1_hsync  <= vga_in.hsync;
         r_s1_vsync  <= vga_in.vsync;
         r_s1_hblnk  <= vga_in.hblnk;
         r_s1_vblnk  <= vga_in.vblnk;
         r_s1_rgb    <= vga_in.rgb;
         if (vga_in.vblnk && !r_s1_vblnk) begin
            r_frame  <= (32'(frame_sel) < FRAMES) ? frame_sel : '0;
            r_mirror <= mirror;
         end
      end
   end

   // Sprite hit test and ROM address, all arithmetic kept at 32 bits
   always_comb begin
      w_rel_x     = 32'(r_s1_hcount) - POS_X;
      w_rel_y     = 32'(r_s1_vcount) - POS_Y;
      w_col       = r_mirror ? (SPR_W - 32'd1 - w_rel_x) : w_rel_x;
      w_addr_full = 32'(r_frame) * SPR_W * SPR_H + w_rel_y * SPR_W + w_col;
      w_inside    = (32'(r_s1_hcount) >= POS_X) && (32'(r_s1_hcount) < POS_X + SPR_W) &&
                    (32'(r_s1_vcount) >= POS_Y) && (32'(r_s1_vcount) < POS_Y + SPR_H) &&
                    !r_s1_hblnk && !r_s1_vblnk;
   end

   assign rom_addr = (w_inside && !rst) ? ADDR_W'(w_addr_full) : '0;

   // Stage 2, aligned with the ROM read data
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_s2_hcount <= 11'd0;
         r_s2_vcount <= 11'd0;
         r_s2_hsync  <= 1'b0;
         r_s2_vsync  <= 1'b0;
         r_s2_hblnk  <= 1'b0;
         r_s2_vblnk  <= 1'b0;
         r_s2_rgb    <= 12'h000;
         r_s2_inside <= 1'b0;
      end else begin
         r_s2_hcount <= r_s1_hcount;
         r_s2_vcount <= r_s1_vcount;
         r_s2_hsync  <= r_s1_hsync;
         r_s2_vsync  <= r_s1_vsync;
         r_s2_hblnk  <= r_s1_hblnk;
         r_s2_vblnk  <= r_s1_vblnk;
         r_s2_rgb    <= r_s1_rgb;
         r_s2_inside <= w_inside;
      end
   end

   // Pixel select: background, sprite, or tinted sprite
   always_comb begin
      w_rgb_out = r_s2_rgb;
      if (r_s2_inside && (rgb_pixel != TRANSP_KEY)) begin
         if (w_tint_on) begin
            w_rgb_out = tint_pixel(rgb_pixel);
         end else begin
            w_rgb_out = rgb_pixel;
         end
      end else begin
         w_rgb_out = r_s2_rgb;
      end
   end

   assign vga_out.hcount = r_s2_hcount;
   assign vga_out.vcount = r_s2_vcount;
   assign vga_out.hsync  = r_s2_hsync;
   assign vga_out.vsync  = r_s2_vsync;
   assign vga_out.hblnk  = r_s2_hblnk;
   assign vga_out.vblnk  = r_s2_vblnk;
   assign vga_out.rgb    = w_rgb_out;

   hit_flash_ctrl #(
      .FLASH_TICKS    (FLASH_TICKS),
      .BLINK_TICKS    (BLINK_TICKS),
      .COOLDOWN_TICKS (COOLDOWN_TICKS)
   ) u_hit_flash_ctrl (
      .clk          (clk),
      .rst          (rst),
      .hit          (hit),
      .flash_active (flash_active),
      .tint_on      (w_tint_on),
      .hit_cnt      (hit_cnt)
   );
endmodule

// File: tb/tb_draw_player_sprite.sv
// Bench for draw_player_sprite: vector table through a scoreboard for the
// datapath, then hand-written hit/flash/cooldown and mid-flash reset sequences.
module tb_draw_player_sprite;
   logic        clk = 1'b0;
   logic        rst;
   logic        hit;
   logic [0:0]  frame_sel;
   logic        mirror;
   logic [11:0] rgb_pixel;
   logic [15:0] rom_addr;
   logic        flash_active;
   logic [7:0]  hit_cnt;
   int          total = 0;
   int          bad   = 0;

   vga_if vin ();
   vga_if vout ();

   draw_player_sprite #(
      .FLASH_TICKS    (20),
      .BLINK_TICKS    (5),
      .COOLDOWN_TICKS (10)
   ) dut (
      .clk          (clk),
      .rst          (rst),
      .hit          (hit),
      .frame_sel    (frame_sel),
      .mirror       (mirror),
      .rgb_pixel    (rgb_pixel),
      .rom_addr     (rom_addr),
      .flash_active (flash_active),
      .hit_cnt      (hit_cnt),
      .vga_in       (vin),
      .vga_out      (vout)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [10:0] hc;
      logic [10:0] vc;
      logic        hs;
      logic        vs;
      logic        hb;
      logic        vb;
      logic [11:0] rgb;
      logic [11:0] pix;
      logic        fs;
      logic        mir;
      logic [15:0] addr;
      logic [11:0] orgb;
   } vec_t;

   localparam int NV = 12;
   vec_t        vecs [NV];
   logic [15:0] addr_q [$];
   vec_t        out_q [$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
      total++;
      if (act !== req) begin
         bad++;
         $display("FAIL %s: got %0h, required %0h", name, act, req);
      end
   endtask

   initial begin
      vec_t        r;
      logic [15:0] ea;
      logic [11:0] exp_rgb;
      int          n_high;

      //          hc       vc      hs    vs    hb    vb    rgb      pix      fs    mir   addr       out rgb
      vecs[0]  = '{11'd0,    11'd0,   1'b0, 1'b1, 1'b0, 1'b1, 12'h123, 12'h000, 1'b1, 1'b0, 16'd0,     12'h123};
      vecs[1]  = '{11'd880,  11'd430, 1'b1, 1'b0, 1'b0, 1'b0, 12'h456, 12'h8A5, 1'b0, 1'b1, 16'd21140, 12'h8A5};
      vecs[2]  = '{11'd881,  11'd430, 1'b0, 1'b0, 1'b0, 1'b0, 12'h456, 12'h0F0, 1'b0, 1'b1, 16'd21141, 12'h456};
      vecs[3]  = '{11'd1019, 11'd580, 1'b1, 1'b1, 1'b0, 1'b0, 12'h456, 12'h0B1, 1'b0, 1'b1, 16'd42279, 12'h0B1};
      vecs[4]  = '{11'd1020, 11'd430, 1'b0, 1'b0, 1'b0, 1'b0, 12'h789, 12'h8A5, 1'b0, 1'b1, 16'd0,     12'h789};
      vecs[5]  = '{11'd880,  11'd581, 1'b0, 1'b0, 1'b0, 1'b0, 12'h789, 12'h8A5, 1'b0, 1'b1, 16'd0,     12'h789};
      vecs[6]  = '{11'd880,  11'd430, 1'b0, 1'b0, 1'b1, 1'b0, 12'h789, 12'h8A5, 1'b0, 1'b1, 16'd0,     12'h789};
      vecs[7]  = '{11'd0,    11'd0,   1'b0, 1'b1, 1'b0, 1'b1, 12'h234, 12'h8A5, 1'b0, 1'b1, 16'd0,     12'h234};
      vecs[8]  = '{11'd880,  11'd430, 1'b0, 1'b0, 1'b0, 1'b0, 12'h456, 12'h8A5, 1'b1, 1'b0, 16'd139,   12'h8A5};
      vecs[9]  = '{11'd879,  11'd430, 1'b0, 1'b0, 1'b0, 1'b0, 12'h3C3, 12'h8A5, 1'b1, 1'b0, 16'd0,     12'h3C3};
      vecs[10] = '{11'd1019, 11'd431, 1'b0, 1'b0, 1'b0, 1'b0, 12'h456, 12'h111, 1'b1, 1'b0, 16'd140,   12'h111};
      vecs[11] = '{11'd1019, 11'd580, 1'b0, 1'b0, 1'b0, 1'b0, 12'h456, 12'h0F0, 1'b1, 1'b0, 16'd21000, 12'h456};

      // Reset with live, inside-sprite input: everything downstream must read 0
      rst = 1'b1; hit = 1'b0; frame_sel = 1'b0; mirror = 1'b0; rgb_pixel = 12'h8A5;
      vin.hcount = 11'd880; vin.vcount = 11'd430; vin.hsync = 1'b1; vin.vsync = 1'b1;
      vin.hblnk = 1'b0; vin.vblnk = 1'b0; vin.rgb = 12'hFFF;
      repeat (3) @(negedge clk);
      check("reset_rom_addr", 32'(rom_addr), 32'd0);
      check("reset_vga_timing", 32'({vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk}), 32'd0);
      check("reset_vga_rgb", 32'(vout.rgb), 32'd0);
      check("reset_flash_active", 32'(flash_active), 32'd0);
      check("reset_hit_cnt", 32'(hit_cnt), 32'd0);
      rst = 1'b0;

      // Datapath vectors: address due 1 clk after drive, rgb/timing 2 clk after
      for (int i = 0; i < NV + 2; i++) begin
         @(negedge clk);
         if (i >= 1 && addr_q.size() > 0) begin
            ea = addr_q.pop_front();
            check($sformatf("rom_addr[%0d]", i - 1), 32'(rom_addr), 32'(ea));
         end
         if (i >= 2 && out_q.size() > 0) begin
            r = out_q.pop_front();
            check($sformatf("vga_rgb[%0d]", i - 2), 32'(vout.rgb), 32'(r.orgb));
            check($sformatf("vga_timing[%0d]", i - 2),
                  32'({vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk}),
                  32'({r.hc, r.vc, r.hs, r.vs, r.hb, r.vb}));
         end
         if (i < NV) begin
            vin.hcount = vecs[i].hc; vin.vcount = vecs[i].vc;
            vin.hsync  = vecs[i].hs; vin.vsync  = vecs[i].vs;
            vin.hblnk  = vecs[i].hb; vin.vblnk  = vecs[i].vb;
            vin.rgb    = vecs[i].rgb;
            frame_sel  = vecs[i].fs; mirror = vecs[i].mir;
            addr_q.push_back(vecs[i].addr);
            out_q.push_back(vecs[i]);
         end
         if (i >= 1 && i <= NV) begin
            rgb_pixel = vecs[i - 1].pix;
         end else begin
            rgb_pixel = 12'h000;
         end
      end

      // Park inside the sprite with an opaque pixel so the tint is visible
      vin.hcount = 11'd880; vin.vcount = 11'd430; vin.hblnk = 1'b0; vin.vblnk = 1'b0;
      vin.rgb = 12'h456; rgb_pixel = 12'h8A5;
      repeat (3) @(negedge clk);
      check("no_flash_pixel", 32'(vout.rgb), 32'h8A5);

      // Flash sequence: extra hits at k=3 (flash) and k=30 (edge on cooldown exit)
      hit = 1'b1;
      n_high = 0;
      for (int k = 1; k <= 36; k++) begin
         @(negedge clk);
         if (k <= 25 && flash_active) n_high++;
         if (k <= 22) begin
            exp_rgb = (k <= 20 && (((k - 1) / 5) % 2) == 0) ? 12'hFA5 : 12'h8A5;
            check($sformatf("tint_rgb[k=%0d]", k), 32'(vout.rgb), 32'(exp_rgb));
         end
         if (k == 10) check("hit_cnt_in_flash", 32'(hit_cnt), 32'd1);
         if (k == 21) check("flash_off_after_20", 32'(flash_active), 32'd0);
         if (k == 30) check("hit_cnt_in_cooldown", 32'(hit_cnt), 32'd1);
         if (k == 32) begin
            check("exit_edge_ignored_flash", 32'(flash_active), 32'd0);
            check("exit_edge_ignored_cnt", 32'(hit_cnt), 32'd1);
         end
         if (k == 34) begin
            check("second_hit_flash", 32'(flash_active), 32'd1);
            check("second_hit_cnt", 32'(hit_cnt), 32'd2);
         end
         case (k)
            1, 4, 32: hit = 1'b0;
            3, 30, 33: hit = 1'b1;
            default: hit = hit;
         endcase
      end
      check("flash_high_cycles", 32'(n_high), 32'd20);

      // Asynchronous reset in the middle of a flash
      #2 rst = 1'b1;
      #1;
      check("midflash_rst_flash", 32'(flash_active), 32'd0);
      check("midflash_rst_hit_cnt", 32'(hit_cnt), 32'd0);
      check("midflash_rst_rom_addr", 32'(rom_addr), 32'd0);
      check("midflash_rst_vga", 32'({vout.hcount, vout.vcount, vout.hsync, vout.vsync, vout.hblnk, vout.vblnk}), 32'd0);
      check("midflash_rst_rgb", 32'(vout.rgb), 32'd0);
      hit = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      hit = 1'b1;
      @(negedge clk);
      check("post_rst_hit_cnt", 32'(hit_cnt), 32'd1);
      check("post_rst_flash", 32'(flash_active), 32'd1);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/draw_player_sprite.md
DRAW_PLAYER_SPRITE -- requirements
Module: draw_player_sprite

Interface
REQ-001 The block SHALL have parameter POS_X, default 880, meaning the sprite's left pixel column.
REQ-002 The block SHALL have parameter POS_Y, default 430, meaning the sprite's top pixel row.
REQ-003 The block SHALL have parameter SPR_W, default 140, meaning the sprite width in pixels.
REQ-004 The block SHALL have parameter SPR_H, default 151, meaning the sprite height in pixels.
REQ-005 The block SHALL have parameter FRAMES, default 2, meaning the number of animation frames stored back to back in the ROM.
REQ-006 The block SHALL have parameter ADDR_W, default 16, meaning the ROM address width; it SHALL be at least clog2(FRAMES*SPR_W*SPR_H).
REQ-007 The block SHALL have parameter TRANSP_KEY, default 12'h0F0, meaning the colour treated as transparent.
REQ-008 The block SHALL have parameter FLASH_TICKS, default 32_500_000, meaning the flash duration in clk cycles.
REQ-009 The block SHALL have parameter BLINK_TICKS, default 4_062_500, meaning the half-period of the tint toggle during flash.
REQ-010 The block SHALL have parameter COOLDOWN_TICKS, default 6_500_000, meaning the cycles during which hits are ignored after a flash.
REQ-011 The block SHALL have port clk, input, 1 bit: the clock; reset rst SHALL be asynchronous and active-high.
REQ-012 The block SHALL have port rst, input, 1 bit: asynchronous active-high reset.
REQ-013 The block SHALL have port hit, input, 1 bit: hit pulse or level, edge-detected internally.
REQ-014 The block SHALL have port frame_sel, input, clog2(FRAMES) bits: the animation frame index.
REQ-015 The block SHALL have port mirror, input, 1 bit: horizontal flip of the sprite.
REQ-016 The block SHALL have port rgb_pixel, input, 12 bits: ROM data, valid 1 clk after rom_addr.
REQ-017 The block SHALL have port rom_addr, output, ADDR_W bits: the sprite ROM address.
REQ-018 The block SHALL have port flash_active, output, 1 bit: high while in the FLASH state.
REQ-019 The block SHALL have port hit_cnt, output, 8 bits: the count of accepted hits, saturating at 255.
REQ-020 The block SHALL have port vga_in, of type vga_if.vga_in: the incoming timing and rgb.
REQ-021 The block SHALL have port vga_out, of type vga_if.vga_out: the outgoing timing and rgb.

Function
REQ-022 Stage 1 SHALL register all vga_in fields; stage 2 SHALL register the stage-1 fields plus an inside flag, and all vga_out timing fields SHALL equal vga_in delayed by exactly 2 clk.
REQ-023 inside SHALL be true when POS_X<=hcount<POS_X+SPR_W, POS_Y<=vcount<POS_Y+SPR_H, !hblnk and !vblnk, all evaluated on stage-1 values.
REQ-024 rom_addr SHALL be computed combinationally from stage 1 as frame_sel*SPR_W*SPR_H + rel_y*SPR_W + (mirror ? SPR_W-1-rel_x : rel_x), with rel_x and rel_y at least 11 bits wide and no truncation before the final ADDR_W.
REQ-025 rom_addr SHALL be 0 when not inside.
REQ-026 frame_sel values >= FRAMES SHALL be treated as 0.
REQ-027 frame_sel and mirror SHALL be sampled only when vblnk rises, so no frame tears mid-frame.
REQ-028 vga_out.rgb SHALL equal the stage-2 rgb when !inside2 or when rgb_pixel==TRANSP_KEY.
REQ-029 Otherwise vga_out.rgb SHALL equal rgb_pixel, or the tinted value when tint_on.
REQ-030 The tint SHALL be red=min(R+4'hA,4'hF) with G and B unchanged, so there is no carry into green.
REQ-031 The hit FSM SHALL have three states: IDLE, FLASH and COOLDOWN.
REQ-032 In IDLE, a rising edge of hit SHALL move the FSM to FLASH, clear the counter, increment hit_cnt (saturating) and set tint_on=1.
REQ-033 In FLASH, the counter SHALL increment every cycle, and tint_on SHALL toggle each BLINK_TICKS.
REQ-034 In FLASH, when the counter reaches FLASH_TICKS-1 the FSM SHALL move to COOLDOWN, clear the counter and set tint_on=0.
REQ-035 In COOLDOWN, when the counter reaches COOLDOWN_TICKS-1 the FSM SHALL move to IDLE.
REQ-036 Hit edges in FLASH or COOLDOWN SHALL be ignored, with no restart and no count.
REQ-037 A hit held high SHALL count once.
REQ-038 A hit edge on the same cycle as the COOLDOWN-to-IDLE transition SHALL be ignored; a new edge is required.
REQ-039 COOLDOWN_TICKS=0 SHALL skip COOLDOWN, returning directly to IDLE.

Reset
REQ-040 Reset SHALL clear all pipeline registers and set the FSM to IDLE, all counters to 0, tint_on=0, hit_cnt=0, flash_active=0 and the hit edge register to 0.
REQ-041 During reset all vga_out fields SHALL be 0 and rom_addr SHALL be 0.
REQ-042 Reset asserted mid-FLASH SHALL return the block to IDLE within the same cycle asynchronously, and the first post-reset hit edge SHALL be accepted.

Structure
REQ-043 The hit_state_e enum (IDLE, FLASH, COOLDOWN) and the tint constant 4'hA SHALL live in a shared package, sprite_pkg.
REQ-044 Timing constants SHALL remain in vga_pkg.
REQ-045 The FSM, counter, blink and hit count logic SHALL be one sub-module, hit_flash_ctrl, with ports clk, rst, hit, flash_active, tint_on and hit_cnt.
REQ-046 The sprite datapath SHALL stay in the top module.

Verification
REQ-047 The bench SHALL drive hcount=880, vcount=430, mirror=0, frame_sel=1 with SPR_W=140, SPR_H=151, and require rom_addr=21140 one clk later.
REQ-048 The bench SHALL drive hcount=880 with mirror=1 and frame_sel=0, and require rom_addr=139; with hcount=879 it SHALL require rom_addr=0 and rgb passthrough.
REQ-049 The bench SHALL return rgb_pixel=12'h0F0 inside the sprite and require vga_out.rgb=input rgb; with rgb_pixel=12'h8A5 and no flash it SHALL require 12'h8A5.
REQ-050 With FLASH_TICKS=20, BLINK_TICKS=5 and COOLDOWN_TICKS=10, one hit pulse SHALL give flash_active high for exactly 20 clk, tint alternating every 5 clk, and a pixel 12'h8A5 SHALL appear as 12'hFA5.
REQ-051 The bench SHALL send a second hit 3 clk into FLASH and a third hit during COOLDOWN, and require hit_cnt=1 with no restart; a hit 1 clk after returning to IDLE SHALL give hit_cnt=2.
REQ-052 The bench SHALL assert rst mid-FLASH and require flash_active=0 immediately with all outputs 0; after release a hit SHALL give hit_cnt=1.
